// File: rtl/decode_ctrl_mdu.sv
// rtl/decode_ctrl_mdu.sv - RV32I/M decode into the D/E register with MDU handshake FSM
module decode_ctrl_mdu #(
    parameter bit M_EXT    = 1'b1,
    parameter bit MUL_FAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_d,
    input  logic        valid_d,
    input  logic        flush_e,
    input  logic        mdu_done,
    output logic        reg_write_e,
    output logic        mem_write_e,
    output logic        jump_e,
    output logic        branch_e,
    output logic [1:0]  res_src_e,
    output logic        alu_src_a_e,
    output logic        alu_src_b_e,
    output logic        adder_src_e,
    output logic [2:0]  imm_src_e,
    output logic [3:0]  alu_control_e,
    output logic [2:0]  mdu_op_e,
    output logic        illegal_e,
    output logic        mdu_start,
    output logic        mdu_kill,
    output logic        stall_fd
);

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [1:0] res_src;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       adder_src;
        logic [2:0] imm_src;
        logic [3:0] alu_control;
        logic [2:0] mdu_op;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = instr_d[6:0];
    assign funct3 = instr_d[14:12];
    assign funct7 = instr_d[31:25];

    // Register and immediate fields are consumed elsewhere in the pipeline.
    logic unused_fields;
    assign unused_fields = ^{instr_d[24:15], instr_d[11:7]};

    logic [3:0] alu_arith;
    always_comb begin
        alu_arith = 4'b0000;
        case (funct3)
            3'b000:  alu_arith = (opcode[5] && funct7[5]) ? 4'b0001 : 4'b0000;
            3'b001:  alu_arith = 4'b0010;
            3'b010:  alu_arith = 4'b0011;
            3'b011:  alu_arith = 4'b0100;
            3'b100:  alu_arith = 4'b0101;
            3'b101:  alu_arith = funct7[5] ? 4'b0111 : 4'b0110;
            3'b110:  alu_arith = 4'b1000;
            default: alu_arith = 4'b1001;
        endcase
    end

    ctrl_t dec;
    logic  dec_long;
    logic  illegal;
    always_comb begin
        dec      = '0;
        dec_long = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            7'b0000011: begin
                dec.reg_write = 1'b1;
                dec.res_src   = 2'b01;
                dec.alu_src_b = 1'b1;
            end
            7'b0010011: begin
                dec.reg_write   = 1'b1;
                dec.alu_src_b   = 1'b1;
                dec.alu_control = alu_arith;
            end
            7'b0010111: begin
                dec.reg_write = 1'b1;
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm_src   = 3'b100;
            end
            7'b0100011: begin
                dec.mem_write = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm_src   = 3'b001;
            end
            7'b0110011: begin
                if (M_EXT && funct7 == 7'b0000001) begin
                    dec.reg_write = 1'b1;
                    dec.res_src   = 2'b11;
                    dec.mdu_op    = funct3;
                    dec_long      = funct3[2] | !MUL_FAST;
                end else if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    dec.reg_write   = 1'b1;
                    dec.alu_control = alu_arith;
                end else begin
                    illegal = 1'b1;
                end
            end
            7'b0110111: begin
                dec.reg_write   = 1'b1;
                dec.alu_src_b   = 1'b1;
                dec.imm_src     = 3'b100;
                dec.alu_control = 4'b1101;
            end
            7'b1100011: begin
                dec.branch  = 1'b1;
                dec.imm_src = 3'b010;
                case (funct3[2:1])
                    2'b00:   dec.alu_control = 4'b1010;
                    2'b10:   dec.alu_control = 4'b1011;
                    2'b11:   dec.alu_control = 4'b1100;
                    default: illegal = 1'b1;
                endcase
            end
            7'b1100111: begin
                dec.reg_write = 1'b1;
                dec.res_src   = 2'b10;
                dec.jump      = 1'b1;
                dec.adder_src = 1'b1;
            end
            7'b1101111: begin
                dec.reg_write = 1'b1;
                dec.res_src   = 2'b10;
                dec.jump      = 1'b1;
                dec.imm_src   = 3'b011;
            end
            default: illegal = 1'b1;
        endcase
        // An illegal instruction carries nothing but its flag into E.
        if (illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            dec_long    = 1'b0;
        end
    end

    state_t state, state_nx;
    ctrl_t  e_q, e_nx;
    logic   start_nx, kill_nx;

    assign stall_fd = (state == BUSY) && !mdu_done && !flush_e;

    always_comb begin
        state_nx = state;
        e_nx     = e_q;
        start_nx = 1'b0;
        kill_nx  = 1'b0;
        if (flush_e) begin
            e_nx     = '0;
            state_nx = IDLE;
            kill_nx  = (state == BUSY);
        end else if (!stall_fd) begin
            e_nx     = valid_d ? dec : '0;
            state_nx = (valid_d && dec_long) ? BUSY : IDLE;
            start_nx = valid_d && dec_long;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            e_q       <= '0;
            mdu_start <= 1'b0;
            mdu_kill  <= 1'b0;
        end else begin
            state     <= state_nx;
            e_q       <= e_nx;
            mdu_start <= start_nx;
            mdu_kill  <= kill_nx;
        end
    end

    assign reg_write_e   = e_q.reg_write;
    assign mem_write_e   = e_q.mem_write;
    assign jump_e        = e_q.jump;
    assign branch_e      = e_q.branch;
    assign res_src_e     = e_q.res_src;
    assign alu_src_a_e   = e_q.alu_src_a;
    assign alu_src_b_e   = e_q.alu_src_b;
    assign adder_src_e   = e_q.adder_src;
    assign imm_src_e     = e_q.imm_src;
    assign alu_control_e = e_q.alu_control;
    assign mdu_op_e      = e_q.mdu_op;
    assign illegal_e     = e_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_mdu.sv
// tb/tb_decode_ctrl_mdu.sv - scoreboard bench for decode_ctrl_mdu across three configurations
module tb_decode_ctrl_mdu;

    localparam logic [31:0] ADDI    = 32'h00A00093;
    localparam logic [31:0] SUB     = 32'h40208033;
    localparam logic [31:0] SRAI    = 32'h4020D093;
    localparam logic [31:0] BNE     = 32'h00209063;
    localparam logic [31:0] DIV     = 32'h0220C033;
    localparam logic [31:0] MUL     = 32'h02208033;
    localparam logic [31:0] BAD_OPC = 32'h0000007F;
    localparam logic [31:0] BEQ_BAD = 32'h0020A063;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr_d;
    logic        valid_d;
    logic        flush_e;
    logic        mdu_done;

    // Per instance: {rw,mw,jump,br,res[1:0],srca,srcb,adder,imm[2:0],alu[3:0],mop[2:0],ill,start,kill,stall}
    wire [22:0] obs [3];

    // Instance 0: defaults; 1: MUL_FAST=0; 2: M_EXT=0.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        decode_ctrl_mdu #(.M_EXT(g != 2), .MUL_FAST(g != 1)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .instr_d       (instr_d),
            .valid_d       (valid_d),
            .flush_e       (flush_e),
            .mdu_done      (mdu_done),
            .reg_write_e   (obs[g][22]),
            .mem_write_e   (obs[g][21]),
            .jump_e        (obs[g][20]),
            .branch_e      (obs[g][19]),
            .res_src_e     (obs[g][18:17]),
            .alu_src_a_e   (obs[g][16]),
            .alu_src_b_e   (obs[g][15]),
            .adder_src_e   (obs[g][14]),
            .imm_src_e     (obs[g][13:11]),
            .alu_control_e (obs[g][10:7]),
            .mdu_op_e      (obs[g][6:4]),
            .illegal_e     (obs[g][3]),
            .mdu_start     (obs[g][2]),
            .mdu_kill      (obs[g][1]),
            .stall_fd      (obs[g][0])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int stall_cnt;
    logic [68:0] exp_q [$];

    logic [19:0] m_e [3];
    bit          m_busy [3];
    bit          m_start [3];
    bit          m_kill [3];

    function automatic logic [19:0] mk(input bit rw, input bit mw, input bit j, input bit b,
                                       input logic [1:0] res, input bit sa, input bit sb, input bit ad,
                                       input logic [2:0] imm, input logic [3:0] alu,
                                       input logic [2:0] mop, input bit ill);
        return {rw, mw, j, b, res, sa, sb, ad, imm, alu, mop, ill};
    endfunction

    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input bit sub, input bit sra);
        logic [3:0] base [8];
        base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (f3 == 3'd0 && sub) return 4'd1;
        if (f3 == 3'd5 && sra) return 4'd7;
        return base[f3];
    endfunction

    function automatic logic [19:0] ref_dec(input logic [31:0] i, input bit mext);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        case (opc)
            7'h03: return mk(1, 0, 0, 0, 2'd1, 0, 1, 0, 3'd0, 4'd0, 3'd0, 0);
            7'h13: return mk(1, 0, 0, 0, 2'd0, 0, 1, 0, 3'd0, ref_alu(f3, 1'b0, i[30]), 3'd0, 0);
            7'h17: return mk(1, 0, 0, 0, 2'd0, 1, 1, 0, 3'd4, 4'd0, 3'd0, 0);
            7'h23: return mk(0, 1, 0, 0, 2'd0, 0, 1, 0, 3'd1, 4'd0, 3'd0, 0);
            7'h33: begin
                if (mext && f7 == 7'h01) return mk(1, 0, 0, 0, 2'd3, 0, 0, 0, 3'd0, 4'd0, f3, 0);
                if (f7 == 7'h00 || f7 == 7'h20)
                    return mk(1, 0, 0, 0, 2'd0, 0, 0, 0, 3'd0, ref_alu(f3, i[30], i[30]), 3'd0, 0);
            end
            7'h37: return mk(1, 0, 0, 0, 2'd0, 0, 1, 0, 3'd4, 4'd13, 3'd0, 0);
            7'h63: begin
                if (f3[2:1] == 2'b00) return mk(0, 0, 0, 1, 2'd0, 0, 0, 0, 3'd2, 4'd10, 3'd0, 0);
                if (f3[2:1] == 2'b10) return mk(0, 0, 0, 1, 2'd0, 0, 0, 0, 3'd2, 4'd11, 3'd0, 0);
                if (f3[2:1] == 2'b11) return mk(0, 0, 0, 1, 2'd0, 0, 0, 0, 3'd2, 4'd12, 3'd0, 0);
            end
            7'h67: return mk(1, 0, 1, 0, 2'd2, 0, 0, 1, 3'd0, 4'd0, 3'd0, 0);
            7'h6F: return mk(1, 0, 1, 0, 2'd2, 0, 0, 0, 3'd3, 4'd0, 3'd0, 0);
            default: ;
        endcase
        return 20'd1;
    endfunction

    function automatic bit ref_long(input logic [31:0] i, input int k);
        return i[6:0] == 7'h33 && i[31:25] == 7'h01 && k != 2 && (i[14] || k == 1);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [12];
        logic [6:0] f7;
        opcs = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h33, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h7F};
        if ($urandom_range(0, 15) == 0) return $urandom;
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 10'($urandom), 3'($urandom), 5'($urandom), opcs[$urandom_range(0, 11)]};
    endfunction

    // The model advances one clock edge using whatever inputs are currently applied.
    task automatic model_step_all();
        bit lng;
        for (int k = 0; k < 3; k++) begin
            if (flush_e) begin
                m_kill[k]  = m_busy[k];
                m_start[k] = 0;
                m_e[k]     = '0;
                m_busy[k]  = 0;
            end else if (m_busy[k] && !mdu_done) begin
                m_start[k] = 0;
                m_kill[k]  = 0;
            end else begin
                lng        = valid_d && ref_long(instr_d, k);
                m_e[k]     = valid_d ? ref_dec(instr_d, k != 2) : '0;
                m_busy[k]  = lng;
                m_start[k] = lng;
                m_kill[k]  = 0;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_e[k] = '0; m_busy[k] = 0; m_start[k] = 0; m_kill[k] = 0;
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic f, input logic d);
        logic [68:0] item;
        @(posedge clk);
        #1;
        instr_d = ins; valid_d = v; flush_e = f; mdu_done = d;
        for (int k = 0; k < 3; k++)
            item[k*23 +: 23] = {m_e[k], m_start[k], m_kill[k], m_busy[k] && !d && !f};
        exp_q.push_back(item);
        model_step_all();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [68:0] item;
        if (exp_q.size() > 0) begin
            item = exp_q.pop_front();
            if (rst_n) begin
                for (int k = 0; k < 3; k++) begin
                    vectors++;
                    if (obs[k] !== item[k*23 +: 23]) begin
                        miscompares++;
                        $display("FAIL scoreboard dut%0d t=%0t got %h expected %h",
                                 k, $time, obs[k], item[k*23 +: 23]);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; instr_d = '0; valid_d = 1'b0; flush_e = 1'b0; mdu_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) check($sformatf("reset_dut%0d", k), 32'(obs[k]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(ADDI, 1, 0, 0);
        drive(SUB, 1, 0, 0);
        #1 check("addi", 32'(obs[0][22:3]), 32'(mk(1, 0, 0, 0, 2'd0, 0, 1, 0, 3'd0, 4'd0, 3'd0, 0)));
        check("addi_stall", 32'(obs[0][0]), 32'd0);
        drive(SRAI, 1, 0, 0);
        #1 check("sub", 32'(obs[0][22:3]), 32'(mk(1, 0, 0, 0, 2'd0, 0, 0, 0, 3'd0, 4'd1, 3'd0, 0)));
        drive(BNE, 1, 0, 0);
        #1 check("srai", 32'(obs[0][22:3]), 32'(mk(1, 0, 0, 0, 2'd0, 0, 1, 0, 3'd0, 4'd7, 3'd0, 0)));
        drive(DIV, 1, 0, 0);
        #1 check("bne", 32'(obs[0][22:3]), 32'(mk(0, 0, 0, 1, 2'd0, 0, 0, 0, 3'd2, 4'd10, 3'd0, 0)));

        stall_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            drive(ADDI, 1, 0, c == 4);
            #1 stall_cnt += int'(obs[0][0]);
            if (c == 0) begin
                check("div_start", 32'(obs[0][2]), 32'd1);
                check("div_fields", 32'(obs[0][22:3]), 32'(mk(1, 0, 0, 0, 2'd3, 0, 0, 0, 3'd0, 4'd0, 3'd4, 0)));
            end
        end
        check("div_stall_cycles", 32'(stall_cnt), 32'd4);
        drive(MUL, 1, 0, 0);
        #1 check("after_done_addi", 32'(obs[0][22:3]), 32'(mk(1, 0, 0, 0, 2'd0, 0, 1, 0, 3'd0, 4'd0, 3'd0, 0)));
        check("after_done_no_start", 32'(obs[0][2]), 32'd0);
        drive(0, 0, 0, 0);
        #1 check("mul_fast_start_stall", 32'(obs[0][2:0]), 32'd0);
        check("mul_slow_start_stall", 32'({obs[1][2], obs[1][0]}), 32'd3);
        drive(0, 0, 0, 1);

        drive(DIV, 1, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 0);
        #1 check("flush_stall_now", 32'(obs[0][0]), 32'd0);
        drive(0, 0, 0, 0);
        #1 check("flush_kill", 32'(obs[0][1]), 32'd1);
        check("flush_nop", 32'(obs[0][22:3]), 32'd0);
        drive(0, 0, 0, 0);
        #1 check("kill_one_cycle", 32'(obs[0][1]), 32'd0);
        drive(DIV, 1, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 1);
        drive(0, 0, 0, 0);
        #1 check("flush_beats_done", 32'(obs[0][1]), 32'd1);

        drive(BAD_OPC, 1, 0, 0);
        drive(BEQ_BAD, 1, 0, 0);
        #1 check("illegal_opcode", 32'(obs[0][22:3]), 32'd1);
        drive(DIV, 1, 0, 0);
        #1 check("illegal_branch", 32'(obs[0][22:3]), 32'd1);
        drive(0, 0, 0, 1);
        #1 check("div_no_mext", 32'(obs[2][22:3]), 32'd1);
        check("div_min_busy", 32'({obs[0][2], obs[0][0]}), 32'd2);

        drive(DIV, 1, 0, 0);
        drive(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check($sformatf("async_reset_dut%0d", k), 32'(obs[k]), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        model_step_all();

        for (int i = 0; i < 3000; i++)
            drive(rand_instr(), $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 8,
                  $urandom_range(0, 99) < 25);
        drive(0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_mdu.md
# decode_ctrl_mdu

Registered decode-stage control unit for the pipelined RV32I core with optional RV32M support. It decodes the instruction in D, loads the control bundle into the D/E pipeline register, and runs a handshake FSM to a multi-cycle multiply/divide unit (MDU). While the MDU is busy, the FSM stalls F/D and holds E. Its outputs feed the execute stage, and its stall output feeds the hazard unit.

## Interface
- `M_EXT`, default 1: 1 decodes RV32M; 0 makes every M opcode illegal.
- `MUL_FAST`, default 1: 1 means MUL* (funct3[2]=0) completes without handshake; DIV/REM always use the handshake.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous reset, active low.
- `instr_d`  in  32  instruction in D.
- `valid_d`  in  1  D holds a real instruction.
- `flush_e`  in  1  kill the instruction entering or held in E; highest priority.
- `mdu_done`  in  1  MDU result valid this cycle.
- `reg_write_e, mem_write_e, jump_e, branch_e`  out  1 each  registered controls.
- `res_src_e`  out  2  00 alu, 01 mem, 10 pc+4, 11 mdu.
- `alu_src_a_e, alu_src_b_e, adder_src_e`  out  1 each.
- `imm_src_e`  out  3.
- `alu_control_e`  out  4.
- `mdu_op_e`  out  3  funct3 of the M instruction in E.
- `illegal_e`  out  1  the instruction in E is illegal.
- `mdu_start`  out  1  one-cycle start pulse to the MDU.
- `mdu_kill`  out  1  one-cycle abort pulse to the MDU.
- `stall_fd`  out  1  hold F and D and hold E; the hazard unit bubbles M.

## Operation
- Decode table (fields not listed are 0; no X outputs):
  - load 0000011: rw=1, res=01, srcb=1, imm=000, alu=0000.
  - op-imm 0010011: rw=1, srcb=1, imm=000.
  - auipc 0010111: rw=1, srca=1, srcb=1, imm=100, alu=0000.
  - store 0100011: mw=1, srcb=1, imm=001, alu=0000.
  - op 0110011: rw=1, srcb=0.
  - lui 0110111: rw=1, srcb=1, imm=100, alu=1101.
  - branch 1100011: br=1, imm=010. funct3 00x gives alu=1010, 10x gives 1011, 11x gives 1100; 01x is illegal.
  - jalr 1100111: rw=1, res=10, jump=1, adder=1, imm=000.
  - jal 1101111: rw=1, res=10, jump=1, imm=011.
- ALU codes from funct3 for op and op-imm:
  - funct3 000: add 0000; sub 0001 only when op[5]=1 and funct7[5]=1.
  - 001: sll 0010. 010: slt 0011. 011: sltu 0100. 100: xor 0101.
  - 101: srl 0110, or sra 0111 when funct7[5]=1.
  - 110: or 1000. 111: and 1001.
- M op (opcode 0110011, funct7=0000001, M_EXT=1):
  - rw=1, res=11, alu=0000, mdu_op_e=funct3.
  - It is "long" if funct3[2]=1 or MUL_FAST=0.
- Illegal:
  - Unknown opcode.
  - funct7 other than 0000000 or 0100000 on op, or 0000001 when M_EXT=0.
  - Branch funct3 01x.
  - Effect: illegal_e=1, and rw, mw, jump, branch are all 0.
- E register load rule, evaluated each edge in this priority order:
  - flush_e: E becomes NOP (all outputs 0).
  - else stall_fd: E holds its value.
  - else valid_d=0: E becomes NOP.
  - else E loads the decode of `instr_d`.
- FSM states are IDLE and BUSY.
  - IDLE to BUSY: E loads a long M op with no flush. `mdu_start` is registered high for the following cycle only.
  - BUSY to IDLE: at the edge where `mdu_done`=1, E loads normally at that same edge.
  - BUSY with `flush_e`=1: go to IDLE, E becomes NOP, and `mdu_kill` is registered high for one cycle. If `mdu_done` is also 1, the flush wins.
- `stall_fd` = (state==BUSY) & ~`mdu_done` & ~`flush_e`, purely combinational.
- Fast MUL and all other ops pass through E in one cycle with no stall.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE and every output 0, including `stall_fd`, `mdu_start`, `mdu_kill` and `illegal_e`.
- Decode-to-E latency is 1 cycle.
- `mdu_start` is high exactly during the first cycle the long op sits in E.
- `mdu_done` is accepted in any BUSY cycle, including the `mdu_start` cycle, giving a minimum of 1 stall-free cycle.
- A back-to-back long op in D while BUSY waits under `stall_fd`. It loads at the `mdu_done` edge and produces a new `mdu_start` on the next cycle.
- Reset asserted mid-BUSY returns to IDLE with no `mdu_kill`; the MDU shares `rst_n`.

## Test plan
- Reset, then `instr_d`=0x00A00093 (addi) with `valid_d`=1 -> after 1 edge: rw=1, srcb=1, alu=0000, imm=000, `stall_fd`=0.
- `instr_d`=0x40208033 (sub) -> alu=0001. 0x4020D093 (srai) -> alu=0111. 0x00209063 (bne) -> br=1, alu=1010, imm=010.
- `instr_d`=0x0220C033 (div), `mdu_done` raised 4 cycles after `mdu_start` -> `mdu_start` 1 cycle; `stall_fd` high 4 cycles; res=11; `mdu_op_e`=100; next instruction enters E on the done edge.
- `instr_d`=0x02208033 (mul) with MUL_FAST=1 -> no `mdu_start`, no stall. With MUL_FAST=0 -> handshake as for div.
- `flush_e` in the 2nd BUSY cycle -> E=NOP, state IDLE, `mdu_kill` 1 cycle, `stall_fd`=0 immediately. With `mdu_done` in the same cycle, the flush still wins.
- M_EXT=0 with a div; opcode 0x7F; beq with funct3=010 -> `illegal_e`=1 and rw=mw=br=jump=0. `rst_n` pulsed low mid-BUSY -> all outputs 0 asynchronously.
